// File: rtl/num_stream_pkg.sv
// ============================================================================
// Module  : num_stream_pkg
// Brief   : Shared defaults, FSM state type and length clamp for num_stream_tx.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package num_stream_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } tx_state_t;

    // Requested element count clamped to the table size.
    function automatic int unsigned sat_len(input int unsigned len, input int unsigned depth);
        return (len > depth) ? depth : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/num_table.sv
// ============================================================================
// Module  : num_table
// Brief   : DEPTH x DATA_W register file, synchronous write and clear,
//           combinational read.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module num_table
    import num_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [CNT_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [CNT_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/num_stream_tx.sv
// ============================================================================
// Module  : num_stream_tx
// Brief   : Loadable number table streamed out over valid/ready with last flag.
//           Optional macro NUM_STREAM_TX_SUM_EN adds the exp_sum running-sum port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module num_stream_tx
    import num_stream_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    localparam int CNT_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [CNT_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              start,
    input  logic [CNT_W:0]    len,
    output logic              busy,
    output logic              done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  m_idx,
`ifdef NUM_STREAM_TX_SUM_EN
    output logic [DATA_W-1:0] exp_sum,
`endif
    output logic              m_last
);

    tx_state_t         r_state;
    logic [CNT_W:0]    r_len;
    logic [CNT_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_data;
    logic              r_valid;
    logic              r_last;
    logic              r_wr_err;

    logic              w_idle;
    logic              w_tbl_we;
    logic              w_hs;
    logic [CNT_W:0]    w_eff_len;
    logic [CNT_W:0]    w_next_idx;
    logic [CNT_W-1:0]  w_rd_addr;
    logic [DATA_W-1:0] w_rd_data;
    logic [DATA_W-1:0] w_beat;

    assign w_idle     = (r_state == IDLE);
    assign w_tbl_we   = wr_en && w_idle;
    assign w_hs       = r_valid && m_ready;
    assign w_eff_len  = (CNT_W+1)'(sat_len(32'(len), DEPTH));
    assign w_next_idx = {1'b0, r_idx} + (CNT_W+1)'(1);

    // In IDLE the read port fetches beat 0; in SEND it prefetches the next beat.
    assign w_rd_addr  = w_idle ? '0 : w_next_idx[CNT_W-1:0];

    // A same-cycle write to entry 0 must be visible to the transfer it starts.
    assign w_beat = (w_tbl_we && (wr_addr == '0)) ? wr_data : w_rd_data;

    num_table #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_table (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_tbl_we),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_len    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_valid  <= 1'b0;
            r_last   <= 1'b0;
            r_wr_err <= 1'b0;
        end else begin
            r_wr_err <= wr_en && !w_idle;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_len <= w_eff_len;
                        r_idx <= '0;
                        if (w_eff_len == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= SEND;
                            r_valid <= 1'b1;
                            r_data  <= w_beat;
                            r_last  <= (w_eff_len == (CNT_W+1)'(1));
                        end
                    end
                end
                SEND: begin
                    if (w_hs) begin
                        if (r_last) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                        end else begin
                            r_idx  <= w_next_idx[CNT_W-1:0];
                            r_data <= w_beat;
                            r_last <= ((w_next_idx + (CNT_W+1)'(1)) == r_len);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef NUM_STREAM_TX_SUM_EN
    logic [DATA_W-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sum <= '0;
        end else if (w_idle && start) begin
            r_sum <= '0;
        end else if (w_hs) begin
            r_sum <= r_sum + r_data;
        end
    end

    assign exp_sum = r_sum;
`endif

    assign wr_err  = r_wr_err;
    assign busy    = !w_idle;
    assign done    = (r_state == DONE);
    assign m_valid = r_valid;
    assign m_data  = r_data;
    assign m_idx   = r_idx;
    assign m_last  = r_last;

endmodule

`default_nettype wire

// File: tb/tb_num_stream_tx.sv
// ============================================================================
// Module  : tb_num_stream_tx
// Brief   : Self-checking bench for num_stream_tx (vector table, corner
//           sequences, randomized transfers against a table model).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_num_stream_tx;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       wr_err;
    logic       start;
    logic [3:0] len;
    logic       busy;
    logic       done;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [2:0] m_idx;
    logic       m_last;
`ifdef NUM_STREAM_TX_SUM_EN
    logic [7:0] exp_sum;
`endif

    num_stream_tx #(.DATA_W(8), .DEPTH(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_err  (wr_err),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .done    (done),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_idx   (m_idx),
`ifdef NUM_STREAM_TX_SUM_EN
        .exp_sum (exp_sum),
`endif
        .m_last  (m_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: table contents plus progress through the current transfer.
    logic [7:0]  mt [8];
    int          eff;
    int          idx;
    int          osum;
    int          msum;

    typedef struct {
        int         len;
        logic [7:0] pat;
        int         exp_beats;
        int         exp_sum;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        mt[a]   = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic load_base();
        logic [7:0] base [8];
        base = '{8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd7, 8'd1, 8'd0};
        for (int i = 0; i < 8; i++) write_entry(i, base[i]);
    endtask

    task automatic start_xfer(input int l);
        start = 1'b1;
        len   = 4'(l);
        eff   = (l > 8) ? 8 : l;
        idx   = 0;
        osum  = 0;
        msum  = 0;
        tick();
        start = 1'b0;
        len   = 4'd0;
        wr_en = 1'b0;
    endtask

    // Runs the stream until done, checking every beat against the model.
    // mode 0: ready from the cyclic pattern, mode 1: random ready.
    task automatic drain(input int mode, input logic [7:0] pat, input int exp_beats);
        int cyc;
        bit got_done;
        bit rdy;
        cyc = 0;
        got_done = 1'b0;
        while (!got_done && cyc < 200) begin
            if (done) begin
                got_done = 1'b1;
                chk("valid_in_done", 32'(m_valid), 0);
                chk("busy_in_done", 32'(busy), 1);
                chk("beats_at_done", idx, eff);
`ifdef NUM_STREAM_TX_SUM_EN
                chk("exp_sum_at_done", 32'(exp_sum), msum % 256);
`endif
            end else begin
                chk("m_valid", 32'(m_valid), 1);
                if (m_valid) begin
                    chk("m_idx", 32'(m_idx), idx);
                    chk("m_data", 32'(m_data), 32'(mt[idx]));
                    chk("m_last", 32'(m_last), (idx == eff - 1) ? 1 : 0);
                end
            end
            rdy = (mode != 0) ? 1'($urandom_range(0, 1)) : pat[cyc % 8];
            m_ready = rdy;
            if (!done && m_valid && rdy) begin
                osum += int'(m_data);
                msum += int'(mt[idx]);
                idx++;
            end
            tick();
            cyc++;
        end
        chk("done_seen", 32'(got_done), 1);
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_after_done", 32'(busy), 0);
        chk("beat_count", idx, exp_beats);
        m_ready = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        len     = '0;
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) mt[i] = 8'd0;
        tick();
        tick();
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_m_idx", 32'(m_idx), 0);
        chk("rst_m_last", 32'(m_last), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_err", 32'(wr_err), 0);
        reset = 1'b0;
        tick();

        // Vector table against the reference table {1,5,9,2,6,7,1,0}.
        vecs[0] = '{7,  8'hFF,       7, 31};
        vecs[1] = '{3,  8'b00101001, 3, 15};
        vecs[2] = '{0,  8'hFF,       0, 0};
        vecs[3] = '{12, 8'hFF,       8, 31};
        vecs[4] = '{1,  8'b00000010, 1, 1};
        vecs[5] = '{8,  8'b01010101, 8, 31};
        load_base();
        for (int v = 0; v < 6; v++) begin
            start_xfer(vecs[v].len);
            drain(0, vecs[v].pat, vecs[v].exp_beats);
            chk("vec_obs_sum", osum, vecs[v].exp_sum);
        end

        // Write while busy is dropped and flagged; the stream keeps the old value.
        m_ready = 1'b0;
        start_xfer(7);
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'h55;
        tick();
        wr_en   = 1'b0;
        chk("wr_err_pulse", 32'(wr_err), 1);
        tick();
        chk("wr_err_clear", 32'(wr_err), 0);
        drain(0, 8'hFF, 7);

        // Write landing in the same IDLE cycle as start is seen by that transfer.
        wr_en   = 1'b1;
        wr_addr = 3'd2;
        wr_data = 8'h55;
        mt[2]   = 8'h55;
        start_xfer(3);
        drain(0, 8'hFF, 3);
        chk("same_cycle_write_sum", osum, 1 + 5 + 8'h55);

        // Start while busy is ignored.
        m_ready = 1'b0;
        start_xfer(3);
        start = 1'b1;
        len   = 4'd8;
        tick();
        start = 1'b0;
        len   = 4'd0;
        drain(0, 8'hFF, 3);

        // Reset mid-transfer aborts and clears the table.
        start_xfer(7);
        m_ready = 1'b1;
        tick();
        tick();
        tick();
        m_ready = 1'b0;
        reset   = 1'b1;
        tick();
        reset   = 1'b0;
        for (int i = 0; i < 8; i++) mt[i] = 8'd0;
        chk("abort_m_valid", 32'(m_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_no_done", 32'(done), 0);
        end
        start_xfer(2);
        drain(0, 8'hFF, 2);
        chk("after_abort_sum", osum, 0);

`ifdef NUM_STREAM_TX_SUM_EN
        write_entry(0, 8'd200);
        write_entry(1, 8'd200);
        start_xfer(2);
        drain(0, 8'hFF, 2);
        tick();
        chk("exp_sum_wrap_hold", 32'(exp_sum), 144);
`endif

        // Randomized transfers with random table updates between them.
        for (int t = 0; t < 20; t++) begin
            int nw;
            int l;
            nw = $urandom_range(0, 3);
            for (int k = 0; k < nw; k++) begin
                write_entry($urandom_range(0, 7), 8'($urandom));
            end
            l = $urandom_range(0, 12);
            start_xfer(l);
            drain(1, 8'h00, (l > 8) ? 8 : l);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
